vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between the VGA scan-out fetch and a pixel-write requester, one RAM operation per CLK.
- Display fetch always has priority. Writes are buffered in a small FIFO and drained in free slots.
- Includes a clear sequencer that fills the whole framebuffer with one colour using write slots only.
- Sits between the VGA timing/colour stage and the framebuffer RAM, in the 50 MHz CLK domain.

---
 rtl/vga_fb_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out
// reads (always highest priority), a buffered pixel-write port and a
// whole-screen clear sequencer. One RAM operation per clock.
// Optional macro FB_ARB_STATS_EN builds the write-stall counter on STALL_CNT.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FB_SIZE    = 307200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PIX_EN,
  input  logic [ADDR_W-1:0] PIX_ADDR,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              WR_VALID,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_READY,
  input  logic              CLEAR_REQ,
  input  logic [DATA_W-1:0] CLEAR_COLOR,
  output logic              CLEAR_BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [15:0]       STALL_CNT
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  // One bit wider than ADDR_W so the clear counter can sit at FB_SIZE as "done"
  localparam logic [ADDR_W:0] FB_END   = (ADDR_W+1)'(FB_SIZE);

  typedef enum logic [0:0] {S_NORMAL, S_CLEAR} state_t;

  state_t r_state, w_state_next;

  // Write FIFO
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_full, w_empty, w_push, w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  // Clear sequencer
  logic [ADDR_W:0]   r_clr_addr;
  logic [DATA_W-1:0] r_clr_color;
  logic              w_clr_done, w_clr_start;

  // Slot grants
  logic              w_slot_clear, w_slot_pop, w_clear_busy;
  logic              w_pix_in_range, w_wr_in_range;

  // Registered RAM interface and read-return pipeline
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we, r_mem_re;
  logic              r_rd_v1, r_rd_in1, r_rd_v2, r_rd_in2;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;

  assign w_full         = (r_count == FULL_CNT);
  assign w_empty        = (r_count == '0);
  assign w_head_addr    = r_fifo_addr[r_rd_ptr];
  assign w_head_data    = r_fifo_data[r_rd_ptr];
  assign w_push         = WR_VALID && !w_full;
  assign w_pop          = w_slot_pop;
  assign w_clr_done     = (r_clr_addr == FB_END);
  assign w_clr_start    = (r_state == S_NORMAL) && CLEAR_REQ;
  assign w_pix_in_range = ({1'b0, PIX_ADDR} < FB_END);
  assign w_wr_in_range  = ({1'b0, w_head_addr} < FB_END);

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_NORMAL;
    else     r_state <= w_state_next;
  end

  // FSM next state: the done state is reached one edge after the last clear write
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_NORMAL: if (CLEAR_REQ)  w_state_next = S_CLEAR;
      S_CLEAR:  if (w_clr_done) w_state_next = S_NORMAL;
      default:                  w_state_next = S_NORMAL;
    endcase
  end

  // FSM outputs: slot arbitration below the display read
  always_comb begin
    w_clear_busy = (r_state == S_CLEAR);
    w_slot_clear = 1'b0;
    w_slot_pop   = 1'b0;
    if (!PIX_EN) begin
      if (r_state == S_CLEAR) w_slot_clear = !w_clr_done;
      else                    w_slot_pop   = !w_empty;
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= WR_ADDR;
      r_fifo_data[r_wr_ptr] <= WR_DATA;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Clear address counter and latched fill colour
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if (w_clr_start) begin
      r_clr_addr  <= '0;
      r_clr_color <= CLEAR_COLOR;
    end else if (w_slot_clear) begin
      r_clr_addr  <= r_clr_addr + 1'b1;
    end else if (w_clear_busy && w_clr_done) begin
      r_clr_addr  <= '0;
    end
  end

  // Registered RAM command for the slot granted at this edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else if (PIX_EN) begin
      // Out-of-range reads still consume the slot but never touch the RAM
      r_mem_addr  <= PIX_ADDR;
      r_mem_re    <= w_pix_in_range;
      r_mem_we    <= 1'b0;
    end else if (w_slot_clear) begin
      r_mem_addr  <= r_clr_addr[ADDR_W-1:0];
      r_mem_wdata <= r_clr_color;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b1;
    end else if (w_slot_pop) begin
      r_mem_addr  <= w_head_addr;
      r_mem_wdata <= w_head_data;
      r_mem_re    <= 1'b0;
      r_mem_we    <= w_wr_in_range;
    end else begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  // Read-return pipeline: command, RAM latency, output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_v1     <= 1'b0;
      r_rd_in1    <= 1'b0;
      r_rd_v2     <= 1'b0;
      r_rd_in2    <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_rd_v1     <= PIX_EN;
      r_rd_in1    <= w_pix_in_range;
      r_rd_v2     <= r_rd_v1;
      r_rd_in2    <= r_rd_in1;
      r_pix_valid <= r_rd_v2;
      if (r_rd_v2) r_pix_data <= r_rd_in2 ? MEM_RDATA : '0;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stall_cnt;
  logic        w_wr_pending;

  assign w_wr_pending = !w_empty || w_clear_busy;

  // Saturating count of cycles a pending write lost its slot to a display read
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                                 r_stall_cnt <= '0;
    else if (PIX_EN && w_wr_pending && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign STALL_CNT = r_stall_cnt;
`else
  assign STALL_CNT = '0;
`endif

  assign WR_READY   = !w_full;
  assign CLEAR_BUSY = w_clear_busy;
  assign MEM_ADDR   = r_mem_addr;
  assign MEM_WDATA  = r_mem_wdata;
  assign MEM_WE     = r_mem_we;
  assign MEM_RE     = r_mem_re;
  assign PIX_VALID  = r_pix_valid;
  assign PIX_DATA   = r_pix_data;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter with a behavioural single-port RAM.
// Uses a reduced FB_SIZE so a full clear finishes quickly.
module tb_vga_fb_arbiter;

  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned FB_SIZE    = 64;
  localparam int unsigned FIFO_DEPTH = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              PIX_EN = 1'b0;
  logic [ADDR_W-1:0] PIX_ADDR = '0;
  logic [DATA_W-1:0] PIX_DATA;
  logic              PIX_VALID;
  logic              WR_VALID = 1'b0;
  logic [ADDR_W-1:0] WR_ADDR = '0;
  logic [DATA_W-1:0] WR_DATA = '0;
  logic              WR_READY;
  logic              CLEAR_REQ = 1'b0;
  logic [DATA_W-1:0] CLEAR_COLOR = '0;
  logic              CLEAR_BUSY;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_WE;
  logic              MEM_RE;
  logic [DATA_W-1:0] MEM_RDATA = '0;
  logic [15:0]       STALL_CNT;

  vga_fb_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FB_SIZE    (FB_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .CLK         (CLK),
    .RST         (RST),
    .PIX_EN      (PIX_EN),
    .PIX_ADDR    (PIX_ADDR),
    .PIX_DATA    (PIX_DATA),
    .PIX_VALID   (PIX_VALID),
    .WR_VALID    (WR_VALID),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .WR_READY    (WR_READY),
    .CLEAR_REQ   (CLEAR_REQ),
    .CLEAR_COLOR (CLEAR_COLOR),
    .CLEAR_BUSY  (CLEAR_BUSY),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_WE      (MEM_WE),
    .MEM_RE      (MEM_RE),
    .MEM_RDATA   (MEM_RDATA),
    .STALL_CNT   (STALL_CNT)
  );

  always #10 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] ram [0:1023];
  logic [ADDR_W-1:0] wq_addr [$];
  logic [DATA_W-1:0] wq_data [$];
  int                both_err = 0;

  logic              pv [3];
  logic [ADDR_W-1:0] pa [3];
  bit                pix_chk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] pat(input int a);
    if (a == 5) return 12'hABC;
    return 12'(a * 37 + 5);
  endfunction

  function automatic logic [DATA_W-1:0] exp_pix(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_W'(FB_SIZE)) return '0;
    return pat(int'(a));
  endfunction

  // RAM model plus write log; sampled at the edge, i.e. the cycle just ending
  always @(posedge CLK) begin
    if (MEM_WE) begin
      ram[MEM_ADDR[9:0]] <= MEM_WDATA;
      wq_addr.push_back(MEM_ADDR);
      wq_data.push_back(MEM_WDATA);
    end
    if (MEM_RE) MEM_RDATA <= ram[MEM_ADDR[9:0]];
    if (MEM_WE && MEM_RE) both_err++;
  end

  // One clock; expected read returns come out three edges after the request
  task automatic tick();
    pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = PIX_EN;
    pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = PIX_ADDR;
    @(posedge CLK);
    #1;
    if (pix_chk) begin
      check_eq("pix_valid", {31'd0, PIX_VALID}, {31'd0, pv[2]});
      if (pv[2]) check_eq("pix_data", {20'd0, PIX_DATA}, {20'd0, exp_pix(pa[2])});
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
  endtask

  task automatic do_reset();
    PIX_EN = 1'b0; WR_VALID = 1'b0; CLEAR_REQ = 1'b0;
    RST = 1'b1;
    clear_pipe();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    int wi;
    int n0;
    logic rdy;
    bit found;

    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    clear_pipe();

    // Reset values
    #5;
    check_eq("rst_mem_re", {31'd0, MEM_RE}, 32'd0);
    check_eq("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
    check_eq("rst_mem_addr", {13'd0, MEM_ADDR}, 32'd0);
    check_eq("rst_wr_ready", {31'd0, WR_READY}, 32'd1);
    check_eq("rst_busy", {31'd0, CLEAR_BUSY}, 32'd0);
    check_eq("rst_pix_valid", {31'd0, PIX_VALID}, 32'd0);
    check_eq("rst_stall", {16'd0, STALL_CNT}, 32'd0);
    do_reset();
    pix_chk = 1'b1;

    // Single read of word 5
    PIX_EN = 1'b1; PIX_ADDR = 19'd5;
    tick();
    check_eq("rd5_mem_re", {31'd0, MEM_RE}, 32'd1);
    check_eq("rd5_mem_addr", {13'd0, MEM_ADDR}, 32'd5);
    PIX_EN = 1'b0;
    tick();
    tick();
    check_eq("rd5_valid", {31'd0, PIX_VALID}, 32'd1);
    check_eq("rd5_data", {20'd0, PIX_DATA}, 32'hABC);
    tick();
    check_eq("rd5_hold", {20'd0, PIX_DATA}, 32'hABC);

    // Alternating reads with four back-to-back writes
    n0 = wq_addr.size();
    for (int k = 0; k < 12; k++) begin
      PIX_EN = (k % 2 == 0); PIX_ADDR = ADDR_W'(20 + k);
      if (k < 4) begin
        WR_VALID = 1'b1; WR_ADDR = ADDR_W'(10 + k); WR_DATA = DATA_W'(1 + k);
        check_eq("alt_wr_ready", {31'd0, WR_READY}, 32'd1);
      end else begin
        WR_VALID = 1'b0;
      end
      tick();
    end
    PIX_EN = 1'b0; WR_VALID = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_eq("alt_wr_count", wq_addr.size() - n0, 32'd4);
    for (int k = 0; k < 4 && n0 + k < wq_addr.size(); k++) begin
      check_eq("alt_wr_addr", {13'd0, wq_addr[n0+k]}, 32'(10 + k));
      check_eq("alt_wr_data", {20'd0, wq_data[n0+k]}, 32'(1 + k));
    end

    // Held display burst starving six writes
    do_reset();
    wi = 0;
    WR_VALID = 1'b1; WR_ADDR = 19'd50; WR_DATA = 12'h100;
    rdy = WR_READY;
    tick();
    if (rdy) wi++;
    n0 = wq_addr.size();
    for (int c = 0; c < 20; c++) begin
      PIX_EN = 1'b1; PIX_ADDR = ADDR_W'(20 + c);
      WR_VALID = (wi < 6); WR_ADDR = ADDR_W'(50 + wi); WR_DATA = DATA_W'(12'h100 + wi);
      rdy = WR_READY;
      tick();
      if (rdy && wi < 6) wi++;
    end
    check_eq("stall_accepts", wi, 32'd4);
    check_eq("stall_wr_ready", {31'd0, WR_READY}, 32'd0);
    check_eq("stall_no_we", wq_addr.size() - n0, 32'd0);
`ifdef FB_ARB_STATS_EN
    check_eq("stall_cnt", {16'd0, STALL_CNT}, 32'd20);
`else
    check_eq("stall_cnt", {16'd0, STALL_CNT}, 32'd0);
`endif
    PIX_EN = 1'b0;
    for (int c = 0; c < 20; c++) begin
      WR_VALID = (wi < 6); WR_ADDR = ADDR_W'(50 + wi); WR_DATA = DATA_W'(12'h100 + wi);
      rdy = WR_READY;
      tick();
      if (rdy && wi < 6) wi++;
    end
    WR_VALID = 1'b0;
    check_eq("drain_accepts", wi, 32'd6);
    check_eq("drain_wr_ready", {31'd0, WR_READY}, 32'd1);
    check_eq("drain_count", wq_addr.size() - n0, 32'd6);
    for (int k = 0; k < 6 && n0 + k < wq_addr.size(); k++) begin
      check_eq("drain_addr", {13'd0, wq_addr[n0+k]}, 32'(50 + k));
      check_eq("drain_data", {20'd0, wq_data[n0+k]}, 32'(12'h100 + k));
    end

    // Out-of-range read returns zero even with stale RAM data
    PIX_EN = 1'b1; PIX_ADDR = 19'd7;
    tick();
    PIX_ADDR = ADDR_W'(FB_SIZE);
    tick();
    check_eq("oor_mem_re", {31'd0, MEM_RE}, 32'd0);
    PIX_EN = 1'b0;
    tick();
    tick();
    check_eq("oor_pix_valid", {31'd0, PIX_VALID}, 32'd1);
    check_eq("oor_pix_data", {20'd0, PIX_DATA}, 32'd0);

    // Out-of-range write is popped without a RAM write
    n0 = wq_addr.size();
    wi = 0;
    PIX_EN = 1'b1; PIX_ADDR = 19'd22;
    for (int c = 0; c < 6 && wi < 4; c++) begin
      WR_VALID = 1'b1;
      WR_ADDR = (wi == 0) ? 19'd400000 : ADDR_W'(11 + wi);
      WR_DATA = DATA_W'(12'h666 + 12'h111 * wi);
      rdy = WR_READY;
      tick();
      if (rdy) wi++;
    end
    WR_VALID = 1'b0;
    check_eq("oorw_full", {31'd0, WR_READY}, 32'd0);
    PIX_EN = 1'b0;
    tick();
    check_eq("oorw_no_we", {31'd0, MEM_WE}, 32'd0);
    check_eq("oorw_ready_back", {31'd0, WR_READY}, 32'd1);
    for (int c = 0; c < 5; c++) tick();
    check_eq("oorw_count", wq_addr.size() - n0, 32'd3);
    for (int k = 0; k < 3 && n0 + k < wq_addr.size(); k++) begin
      check_eq("oorw_addr", {13'd0, wq_addr[n0+k]}, 32'(12 + k));
      check_eq("oorw_data", {20'd0, wq_data[n0+k]}, 32'(12'h777 + 12'h111 * k));
    end
    check_eq("both_strobes", both_err, 32'd0);

    // Full clear with a queued write and an ignored second request
    wq_addr.delete();
    wq_data.delete();
    CLEAR_REQ = 1'b1; CLEAR_COLOR = 12'h00F;
    tick();
    CLEAR_REQ = 1'b0;
    check_eq("clr_busy", {31'd0, CLEAR_BUSY}, 32'd1);
    for (int c = 0; c < 10; c++) tick();
    WR_VALID = 1'b1; WR_ADDR = 19'd30; WR_DATA = 12'h5A5;
    CLEAR_REQ = 1'b1; CLEAR_COLOR = 12'hFFF;
    check_eq("clr_wr_ready", {31'd0, WR_READY}, 32'd1);
    tick();
    WR_VALID = 1'b0; CLEAR_REQ = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (MEM_WE && MEM_ADDR == ADDR_W'(FB_SIZE - 1)) begin
        found = 1'b1;
        check_eq("clr_busy_last", {31'd0, CLEAR_BUSY}, 32'd1);
        tick();
        check_eq("clr_busy_fall", {31'd0, CLEAR_BUSY}, 32'd0);
      end
    end
    check_eq("clr_last_seen", {31'd0, found}, 32'd1);
    for (int c = 0; c < 6; c++) tick();
    check_eq("clr_we_count", wq_addr.size(), 32'(FB_SIZE + 1));
    for (int k = 0; k < int'(FB_SIZE) && k < wq_addr.size(); k++) begin
      check_eq("clr_addr", {13'd0, wq_addr[k]}, 32'(k));
      check_eq("clr_data", {20'd0, wq_data[k]}, 32'h00F);
    end
    if (wq_addr.size() > FB_SIZE) begin
      check_eq("clr_tail_addr", {13'd0, wq_addr[FB_SIZE]}, 32'd30);
      check_eq("clr_tail_data", {20'd0, wq_data[FB_SIZE]}, 32'h5A5);
    end
    check_eq("ram30", {20'd0, ram[30]}, 32'h5A5);
    check_eq("ram31", {20'd0, ram[31]}, 32'h00F);

    // Reset in the middle of a clear, then restart
    CLEAR_REQ = 1'b1; CLEAR_COLOR = 12'h0F0;
    tick();
    CLEAR_REQ = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (MEM_WE && MEM_ADDR == 19'd40) found = 1'b1;
    end
    check_eq("rclr_seen40", {31'd0, found}, 32'd1);
    #2;
    RST = 1'b1;
    clear_pipe();
    #1;
    check_eq("rclr_we", {31'd0, MEM_WE}, 32'd0);
    check_eq("rclr_re", {31'd0, MEM_RE}, 32'd0);
    check_eq("rclr_addr", {13'd0, MEM_ADDR}, 32'd0);
    check_eq("rclr_wdata", {20'd0, MEM_WDATA}, 32'd0);
    check_eq("rclr_busy", {31'd0, CLEAR_BUSY}, 32'd0);
    check_eq("rclr_ready", {31'd0, WR_READY}, 32'd1);
    check_eq("rclr_valid", {31'd0, PIX_VALID}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_eq("rclr_kept39", {20'd0, ram[39]}, 32'h0F0);
    check_eq("rclr_kept41", {20'd0, ram[41]}, 32'h00F);
    CLEAR_REQ = 1'b1; CLEAR_COLOR = 12'h333;
    tick();
    CLEAR_REQ = 1'b0;
    tick();
    check_eq("restart_we", {31'd0, MEM_WE}, 32'd1);
    check_eq("restart_addr", {13'd0, MEM_ADDR}, 32'd0);
    check_eq("restart_data", {20'd0, MEM_WDATA}, 32'h333);
    tick();
    check_eq("restart_addr1", {13'd0, MEM_ADDR}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
